// File: rtl/grant_pacer_if.sv
// Grant FIFO handshake bundle: upstream FWFT pop side and downstream push side.
interface grant_pacer_if #(
  parameter int GRANT_W = 95
);
  logic               grant_in_empty_i;
  logic               grant_in_read_en_o;
  logic [GRANT_W-1:0] grant_in_data_i;
  logic               grant_out_full_i;
  logic               grant_out_write_en_o;
  logic [GRANT_W-1:0] grant_out_data_o;

  // Pacer side.
  modport slave (
    input  grant_in_empty_i,
    input  grant_in_data_i,
    input  grant_out_full_i,
    output grant_in_read_en_o,
    output grant_out_write_en_o,
    output grant_out_data_o
  );

  // Environment side: the FIFOs around the pacer.
  modport master (
    output grant_in_empty_i,
    output grant_in_data_i,
    output grant_out_full_i,
    input  grant_in_read_en_o,
    input  grant_out_write_en_o,
    input  grant_out_data_o
  );
endinterface

// File: rtl/grant_pacer.sv
// Grant pacer: holds one grant at a time and releases it only while the total
// of granted-but-unreceived bytes stays within BUDGET_BYTES.
module grant_pacer #(
  parameter logic [31:0] BUDGET_BYTES = 32'd65536,
  parameter int          GRANT_W      = 95
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          enable_i,
  grant_pacer_if.slave  gif,
  input  logic          credit_valid_i,
  input  logic [31:0]   credit_bytes_i,
  output logic [31:0]   outstanding_o,
  output logic [15:0]   stall_cnt_o,
  output logic          underflow_o
);

  localparam int INC_LSB = 35;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         rst_sync_q, rst_sync_d;
  logic [GRANT_W-1:0] hold_q, hold_d;
  logic [31:0]        outstanding_q, outstanding_d;
  logic [15:0]        stall_q, stall_d;
  logic               underflow_q, underflow_d;

  logic               fetch_ok;
  logic               read_en;
  logic               write_en;
  logic [31:0]        inc;
  logic [32:0]        sum33;
  logic [32:0]        add33;
  logic [32:0]        credit33;
  logic [32:0]        diff33;
  logic               eligible;

  // Reset release is walked through two flops so fetching starts cleanly
  // after the second rising edge following deassertion.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  assign fetch_ok = rst_sync_q[1];
  assign inc      = hold_q[INC_LSB +: 32];
  assign sum33    = {1'b0, outstanding_q} + {1'b0, inc};

  // An oversize grant may go alone once everything before it is received.
  assign eligible = (sum33 <= {1'b0, BUDGET_BYTES}) ||
                    ((inc > BUDGET_BYTES) && (outstanding_q == 32'd0));

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    stall_d  = stall_q;
    read_en  = 1'b0;
    write_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (fetch_ok && enable_i && !gif.grant_in_empty_i) begin
          read_en = 1'b1;
          hold_d  = gif.grant_in_data_i;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (eligible) begin
          if (!gif.grant_out_full_i) begin
            write_en = 1'b1;
            state_d  = IDLE;
          end
        end else if (stall_q != 16'hFFFF) begin
          stall_d = stall_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Emit and credit settle in one update; over-crediting clamps to zero.
  always_comb begin
    outstanding_d = outstanding_q;
    underflow_d   = underflow_q;
    add33         = write_en ? sum33 : {1'b0, outstanding_q};
    credit33      = credit_valid_i ? {1'b0, credit_bytes_i} : 33'd0;
    diff33        = add33 - credit33;
    if (credit33 > add33) begin
      outstanding_d = 32'd0;
      underflow_d   = 1'b1;
    end else if (diff33[32]) begin
      outstanding_d = 32'hFFFF_FFFF;
    end else begin
      outstanding_d = diff33[31:0];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rst_sync_q    <= 2'b00;
      state_q       <= IDLE;
      hold_q        <= '0;
      outstanding_q <= 32'd0;
      stall_q       <= 16'd0;
      underflow_q   <= 1'b0;
    end else begin
      rst_sync_q    <= rst_sync_d;
      state_q       <= state_d;
      hold_q        <= hold_d;
      outstanding_q <= outstanding_d;
      stall_q       <= stall_d;
      underflow_q   <= underflow_d;
    end
  end

  assign gif.grant_in_read_en_o   = read_en;
  assign gif.grant_out_write_en_o = write_en;
  assign gif.grant_out_data_o     = hold_q;
  assign outstanding_o            = outstanding_q;
  assign stall_cnt_o              = stall_q;
  assign underflow_o              = underflow_q;

endmodule

// File: tb/tb_grant_pacer.sv
// Directed bench for grant_pacer: a vector table for the main flow plus
// hand-written sequences for budget stall, full back-pressure, oversize grants,
// credit underflow and reset during HOLD.
module tb_grant_pacer;
  localparam int GW = 95;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        enable_i;
  logic        credit_valid_i;
  logic [31:0] credit_bytes_i;
  logic [31:0] outstanding_o;
  logic [15:0] stall_cnt_o;
  logic        underflow_o;

  always #5 ap_clk = ~ap_clk;

  grant_pacer_if #(.GRANT_W(GW)) gif ();

  grant_pacer #(.BUDGET_BYTES(32'd65536), .GRANT_W(GW)) dut (
    .ap_clk         (ap_clk),
    .ap_rst_n       (ap_rst_n),
    .enable_i       (enable_i),
    .gif            (gif),
    .credit_valid_i (credit_valid_i),
    .credit_bytes_i (credit_bytes_i),
    .outstanding_o  (outstanding_o),
    .stall_cnt_o    (stall_cnt_o),
    .underflow_o    (underflow_o)
  );

  typedef struct {
    logic        en, empty, full, cv;
    logic [31:0] cb, inc;
    logic        rd, wr;
    logic [31:0] out;
    logic [15:0] stall;
  } vec_t;

  vec_t vecs [15];
  int   nchk = 0;
  int   nerr = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_w(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [GW-1:0] mkw(input logic [13:0] peer, input logic [31:0] inc);
    return {peer, ~peer, inc, {3'b101, ~inc}};
  endfunction

  function automatic vec_t mkv(input logic en, input logic empty, input logic full,
                               input logic cv, input logic [31:0] cb, input logic [31:0] inc,
                               input logic rd, input logic wr, input logic [31:0] out,
                               input logic [15:0] stall);
    vec_t v;
    v.en = en; v.empty = empty; v.full = full; v.cv = cv; v.cb = cb; v.inc = inc;
    v.rd = rd; v.wr = wr; v.out = out; v.stall = stall;
    return v;
  endfunction

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic do_reset();
    ap_rst_n               = 1'b0;
    enable_i               = 1'b1;
    gif.grant_in_empty_i   = 1'b1;
    gif.grant_in_data_i    = '0;
    gif.grant_out_full_i   = 1'b0;
    credit_valid_i         = 1'b0;
    credit_bytes_i         = 32'd0;
    step();
    step();
    ap_rst_n = 1'b1;
    step();
    step();
  endtask

  task automatic fetch(input logic [GW-1:0] w);
    gif.grant_in_empty_i = 1'b0;
    gif.grant_in_data_i  = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [GW-1:0] w, held, w1, w2, w3, w6;

    vecs[0]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0,     32'd16,    1'b1, 1'b0, 32'd0,     16'd0);
    vecs[1]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0,     32'd100,   1'b0, 1'b1, 32'd0,     16'd0);
    vecs[2]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0,     32'd100,   1'b1, 1'b0, 32'd16,    16'd0);
    vecs[3]  = mkv(1'b1, 1'b0, 1'b1, 1'b0, 32'd0,     32'd100,   1'b0, 1'b0, 32'd16,    16'd0);
    vecs[4]  = mkv(1'b1, 1'b0, 1'b0, 1'b1, 32'd6,     32'd100,   1'b0, 1'b1, 32'd16,    16'd0);
    vecs[5]  = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,     32'd7,     1'b0, 1'b0, 32'd110,   16'd0);
    vecs[6]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 32'd0,     32'd7,     1'b0, 1'b0, 32'd110,   16'd0);
    vecs[7]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0,     32'd65426, 1'b1, 1'b0, 32'd110,   16'd0);
    vecs[8]  = mkv(1'b1, 1'b1, 1'b0, 1'b0, 32'd0,     32'd65426, 1'b0, 1'b1, 32'd110,   16'd0);
    vecs[9]  = mkv(1'b1, 1'b0, 1'b0, 1'b0, 32'd0,     32'd1,     1'b1, 1'b0, 32'd65536, 16'd0);
    vecs[10] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 32'd0,     32'd1,     1'b0, 1'b0, 32'd65536, 16'd0);
    vecs[11] = mkv(1'b1, 1'b1, 1'b0, 1'b1, 32'd1,     32'd1,     1'b0, 1'b0, 32'd65536, 16'd1);
    vecs[12] = mkv(1'b1, 1'b1, 1'b0, 1'b0, 32'd0,     32'd1,     1'b0, 1'b1, 32'd65535, 16'd2);
    vecs[13] = mkv(1'b0, 1'b0, 1'b0, 1'b1, 32'd65536, 32'd1,     1'b0, 1'b0, 32'd65536, 16'd2);
    vecs[14] = mkv(1'b0, 1'b0, 1'b0, 1'b0, 32'd0,     32'd1,     1'b0, 1'b0, 32'd0,     16'd2);

    // Reset values held while inputs try to provoke activity.
    ap_rst_n             = 1'b0;
    enable_i             = 1'b1;
    gif.grant_in_empty_i = 1'b0;
    gif.grant_in_data_i  = mkw(14'd1, 32'd16);
    gif.grant_out_full_i = 1'b0;
    credit_valid_i       = 1'b1;
    credit_bytes_i       = 32'd5;
    step();
    chk_b ("rst_rd", gif.grant_in_read_en_o, 1'b0);
    chk_b ("rst_wr", gif.grant_out_write_en_o, 1'b0);
    chk_32("rst_out", outstanding_o, 32'd0);
    chk_32("rst_stall", {16'd0, stall_cnt_o}, 32'd0);
    chk_b ("rst_uf", underflow_o, 1'b0);
    chk_w ("rst_data", gif.grant_out_data_o, '0);
    step();
    ap_rst_n       = 1'b1;
    credit_valid_i = 1'b0;
    #1 chk_b("rel0_rd", gif.grant_in_read_en_o, 1'b0);
    step();
    chk_b("rel1_rd", gif.grant_in_read_en_o, 1'b0);
    step();
    chk_b("rel2_rd", gif.grant_in_read_en_o, 1'b1);
    $display("reset release: first fetch strobe after second edge");
    gif.grant_in_empty_i = 1'b1;

    held = '0;
    for (int i = 0; i < 15; i++) begin
      w                    = mkw(14'(i), vecs[i].inc);
      enable_i             = vecs[i].en;
      gif.grant_in_empty_i = vecs[i].empty;
      gif.grant_in_data_i  = w;
      gif.grant_out_full_i = vecs[i].full;
      credit_valid_i       = vecs[i].cv;
      credit_bytes_i       = vecs[i].cb;
      #1;
      chk_b ($sformatf("vec%0d_rd", i), gif.grant_in_read_en_o, vecs[i].rd);
      chk_b ($sformatf("vec%0d_wr", i), gif.grant_out_write_en_o, vecs[i].wr);
      chk_32($sformatf("vec%0d_out", i), outstanding_o, vecs[i].out);
      chk_32($sformatf("vec%0d_stall", i), {16'd0, stall_cnt_o}, {16'd0, vecs[i].stall});
      chk_b ($sformatf("vec%0d_uf", i), underflow_o, 1'b0);
      if (vecs[i].wr) chk_w($sformatf("vec%0d_data", i), gif.grant_out_data_o, held);
      if (vecs[i].rd) held = w;
      $display("vec %0d: rd=%b wr=%b out=%0d stall=%0d", i, gif.grant_in_read_en_o,
               gif.grant_out_write_en_o, outstanding_o, stall_cnt_o);
      step();
    end

    // Minimum latency: read in N, write in N+1.
    do_reset();
    w1 = mkw(14'h1234, 32'd16);
    fetch(w1);
    #1 chk_b("lat_rd", gif.grant_in_read_en_o, 1'b1);
    chk_b("lat_wr0", gif.grant_out_write_en_o, 1'b0);
    step();
    gif.grant_in_empty_i = 1'b1;
    #1 chk_b("lat_wr", gif.grant_out_write_en_o, 1'b1);
    chk_b("lat_rd1", gif.grant_in_read_en_o, 1'b0);
    chk_w("lat_data", gif.grant_out_data_o, w1);
    step();
    chk_32("lat_out", outstanding_o, 32'd16);
    $display("latency seq: out=%0d", outstanding_o);

    // Budget stall released by a credit.
    do_reset();
    fetch(mkw(14'd2, 32'd65530));
    step();
    gif.grant_in_empty_i = 1'b1;
    #1 chk_b("bud_wr_a", gif.grant_out_write_en_o, 1'b1);
    step();
    w2 = mkw(14'd3, 32'd16);
    fetch(w2);
    #1 chk_32("bud_out_a", outstanding_o, 32'd65530);
    chk_b("bud_rd", gif.grant_in_read_en_o, 1'b1);
    step();
    gif.grant_in_empty_i = 1'b1;
    #1 chk_b("bud_wr0", gif.grant_out_write_en_o, 1'b0);
    chk_32("bud_st0", {16'd0, stall_cnt_o}, 32'd0);
    step();
    chk_b("bud_wr1", gif.grant_out_write_en_o, 1'b0);
    chk_32("bud_st1", {16'd0, stall_cnt_o}, 32'd1);
    step();
    credit_valid_i = 1'b1;
    credit_bytes_i = 32'd10;
    #1 chk_b("bud_wr2", gif.grant_out_write_en_o, 1'b0);
    chk_32("bud_st2", {16'd0, stall_cnt_o}, 32'd2);
    step();
    credit_valid_i = 1'b0;
    #1 chk_b("bud_wr3", gif.grant_out_write_en_o, 1'b1);
    chk_w("bud_data", gif.grant_out_data_o, w2);
    chk_32("bud_st3", {16'd0, stall_cnt_o}, 32'd3);
    step();
    chk_32("bud_out", outstanding_o, 32'd65536);
    chk_32("bud_st4", {16'd0, stall_cnt_o}, 32'd3);
    $display("budget seq: out=%0d stall=%0d", outstanding_o, stall_cnt_o);

    // Downstream full does not count as a budget stall.
    do_reset();
    gif.grant_out_full_i = 1'b1;
    w3 = mkw(14'd4, 32'd40);
    fetch(w3);
    #1 chk_b("full_rd", gif.grant_in_read_en_o, 1'b1);
    step();
    for (int k = 0; k < 5; k++) begin
      gif.grant_in_data_i = mkw(14'd5, 32'd99);
      #1 chk_b($sformatf("full%0d_wr", k), gif.grant_out_write_en_o, 1'b0);
      chk_b($sformatf("full%0d_rd", k), gif.grant_in_read_en_o, 1'b0);
      chk_w($sformatf("full%0d_data", k), gif.grant_out_data_o, w3);
      chk_32($sformatf("full%0d_st", k), {16'd0, stall_cnt_o}, 32'd0);
      step();
    end
    gif.grant_out_full_i = 1'b0;
    gif.grant_in_empty_i = 1'b1;
    #1 chk_b("full_wr", gif.grant_out_write_en_o, 1'b1);
    chk_w("full_data", gif.grant_out_data_o, w3);
    step();
    chk_32("full_out", outstanding_o, 32'd40);
    chk_32("full_st", {16'd0, stall_cnt_o}, 32'd0);
    $display("full seq: out=%0d stall=%0d", outstanding_o, stall_cnt_o);

    // Oversize grant goes alone; next one waits for 0xFFFF0063 of credit.
    do_reset();
    fetch(mkw(14'd6, 32'hFFFF_FFFF));
    step();
    gif.grant_in_empty_i = 1'b1;
    #1 chk_b("big_wr", gif.grant_out_write_en_o, 1'b1);
    step();
    fetch(mkw(14'd7, 32'd100));
    #1 chk_32("big_out", outstanding_o, 32'hFFFF_FFFF);
    chk_b("big_rd", gif.grant_in_read_en_o, 1'b1);
    step();
    gif.grant_in_empty_i = 1'b1;
    credit_valid_i       = 1'b1;
    credit_bytes_i       = 32'hFFFF_0062;
    #1 chk_b("big_wr0", gif.grant_out_write_en_o, 1'b0);
    step();
    credit_bytes_i = 32'd1;
    #1 chk_32("big_out1", outstanding_o, 32'd65437);
    chk_b("big_wr1", gif.grant_out_write_en_o, 1'b0);
    step();
    credit_valid_i = 1'b0;
    #1 chk_32("big_out2", outstanding_o, 32'd65436);
    chk_b("big_wr2", gif.grant_out_write_en_o, 1'b1);
    step();
    chk_32("big_out3", outstanding_o, 32'd65536);
    $display("oversize seq: out=%0d", outstanding_o);

    // Same-cycle emit and over-credit.
    do_reset();
    fetch(mkw(14'd8, 32'd4));
    step();
    gif.grant_in_empty_i = 1'b1;
    step();
    fetch(mkw(14'd9, 32'd8));
    #1 chk_32("uf_out4", outstanding_o, 32'd4);
    step();
    gif.grant_in_empty_i = 1'b1;
    credit_valid_i       = 1'b1;
    credit_bytes_i       = 32'd20;
    #1 chk_b("uf_wr", gif.grant_out_write_en_o, 1'b1);
    chk_b("uf_pre", underflow_o, 1'b0);
    step();
    credit_valid_i = 1'b0;
    #1 chk_32("uf_out", outstanding_o, 32'd0);
    chk_b("uf_set", underflow_o, 1'b1);
    step();
    step();
    chk_b("uf_sticky", underflow_o, 1'b1);
    $display("underflow seq: out=%0d uf=%b", outstanding_o, underflow_o);

    // Reset while holding discards the entry; the next grant flows normally.
    do_reset();
    fetch(mkw(14'd10, 32'd30));
    step();
    gif.grant_in_empty_i = 1'b1;
    step();
    gif.grant_out_full_i = 1'b1;
    fetch(mkw(14'd11, 32'd50));
    #1 chk_32("rh_out30", outstanding_o, 32'd30);
    step();
    gif.grant_in_empty_i = 1'b1;
    #1 chk_b("rh_hold_wr", gif.grant_out_write_en_o, 1'b0);
    step();
    ap_rst_n             = 1'b0;
    gif.grant_out_full_i = 1'b0;
    w6                   = mkw(14'd12, 32'd24);
    fetch(w6);
    #1 chk_b("rh_wr", gif.grant_out_write_en_o, 1'b0);
    chk_b("rh_rd", gif.grant_in_read_en_o, 1'b0);
    chk_32("rh_out", outstanding_o, 32'd0);
    chk_32("rh_st", {16'd0, stall_cnt_o}, 32'd0);
    chk_b("rh_uf", underflow_o, 1'b0);
    chk_w("rh_data", gif.grant_out_data_o, '0);
    step();
    ap_rst_n = 1'b1;
    #1 chk_b("rh_rel0_wr", gif.grant_out_write_en_o, 1'b0);
    step();
    chk_b("rh_rel1_rd", gif.grant_in_read_en_o, 1'b0);
    chk_b("rh_rel1_wr", gif.grant_out_write_en_o, 1'b0);
    step();
    chk_b("rh_rel2_rd", gif.grant_in_read_en_o, 1'b1);
    chk_b("rh_rel2_wr", gif.grant_out_write_en_o, 1'b0);
    step();
    gif.grant_in_empty_i = 1'b1;
    #1 chk_b("rh_new_wr", gif.grant_out_write_en_o, 1'b1);
    chk_w("rh_new_data", gif.grant_out_data_o, w6);
    step();
    chk_32("rh_new_out", outstanding_o, 32'd24);
    $display("reset-in-hold seq: out=%0d", outstanding_o);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
